acia_master: RTL and testbench

- Bus-master sequencer that owns the CPU-side register port of the 6850-style ACIA.
- After reset, it issues a master reset to the ACIA and then writes a fixed control word.
- It then polls the status register in a loop:
  - drains received bytes to a single consumer;
  - shares the transmitter between two byte-stream requesters using round-robin arbitration.
- It sits between the ACIA and hardware byte sources/sinks (console mux, debug dumper) so that no CPU is needed to run the UART.

---
 rtl/acia_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 46 ++++
 rtl/acia_master.sv | 137 +++++++++++++
 tb/tb_acia_master.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA bus-master sequencer: state encoding,
// ACIA status bit positions and default control bytes.
package acia_pkg;

   typedef enum logic [2:0] {
      S_MRST  = 3'd0,
      S_CFG   = 3'd1,
      S_POLL  = 3'd2,
      S_EVAL  = 3'd3,
      S_RXRD  = 3'd4,
      S_RXCAP = 3'd5,
      S_TX    = 3'd6,
      S_GAP   = 3'd7
   } state_t;

   localparam int ACIA_ST_RXF = 0;
   localparam int ACIA_ST_TXE = 1;
   localparam int ACIA_ST_FE  = 4;
   localparam int ACIA_ST_OVR = 5;
   localparam int ACIA_ST_IRQ = 7;

   // div-select 01, word 101, tx-ctrl 00, RIE 0
   localparam logic [7:0] DEF_CTRL_WORD = 8'h15;
   localparam logic [7:0] DEF_MRST_WORD = 8'h03;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grant latched on i_load, history updated on i_upd.
module rr_arb2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_load,
   input  logic i_upd,
   output logic o_gnt,
   output logic o_any
);

   logic r_last;
   logic r_gnt;
   logic w_gnt;

   // On a tie the requester that did not win last time is chosen.
   always_comb begin
      w_gnt = 1'b0;
      if (i_req0 && i_req1) begin
         w_gnt = ~r_last;
      end else if (i_req1) begin
         w_gnt = 1'b1;
      end else begin
         w_gnt = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= 1'b1;
         r_gnt  <= 1'b0;
      end else begin
         if (i_load) begin
            r_gnt <= w_gnt;
         end
         if (i_upd) begin
            r_last <= r_gnt;
         end
      end
   end

   assign o_gnt = r_gnt;
   assign o_any = i_req0 | i_req1;

endmodule

// File: rtl/acia_master.sv
// ACIA bus-master: resets and configures the ACIA, then polls status,
// drains received bytes and shares the transmitter between two requesters.
module acia_master
   import acia_pkg::*;
#(
   parameter logic [7:0] CTRL_WORD = DEF_CTRL_WORD,
   parameter logic [7:0] MRST_WORD = DEF_MRST_WORD
) (
   input  logic       clk,
   input  logic       rst,
   output logic       acia_cs,
   output logic       acia_we,
   output logic       acia_rs,
   output logic [7:0] acia_din,
   input  logic [7:0] acia_dout,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic [7:0] status,
   output logic       init_done
);

   state_t     r_state;
   logic       r_rx_valid;
   logic [7:0] r_rx_data;
   logic [7:0] r_status;
   logic       r_init_done;
   logic       w_gnt;
   logic       w_any;

   rr_arb2 u_arb (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_req0 (req0_valid),
      .i_req1 (req1_valid),
      .i_load (r_state == S_EVAL),
      .i_upd  (r_state == S_TX),
      .o_gnt  (w_gnt),
      .o_any  (w_any)
   );

   // Strobes are decoded from the state and suppressed while rst is high,
   // so an in-flight write is dropped in the reset cycle.
   always_comb begin
      acia_cs    = 1'b0;
      acia_we    = 1'b0;
      acia_rs    = 1'b0;
      acia_din   = 8'h00;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst) begin
         case (r_state)
            S_MRST: begin
               acia_cs  = 1'b1;
               acia_we  = 1'b1;
               acia_din = MRST_WORD;
            end
            S_CFG: begin
               acia_cs  = 1'b1;
               acia_we  = 1'b1;
               acia_din = CTRL_WORD;
            end
            S_POLL: begin
               acia_cs = 1'b1;
            end
            S_RXRD: begin
               acia_cs = 1'b1;
               acia_rs = 1'b1;
            end
            S_TX: begin
               acia_cs    = 1'b1;
               acia_we    = 1'b1;
               acia_rs    = 1'b1;
               acia_din   = w_gnt ? req1_data : req0_data;
               req0_ready = ~w_gnt;
               req1_ready = w_gnt;
            end
            default: begin
               acia_cs = 1'b0;
            end
         endcase
      end else begin
         acia_cs = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_MRST;
         r_rx_valid  <= 1'b0;
         r_rx_data   <= 8'h00;
         r_status    <= 8'h00;
         r_init_done <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            S_MRST:  r_state <= S_CFG;
            S_CFG: begin
               r_init_done <= 1'b1;
               r_state     <= S_POLL;
            end
            S_POLL:  r_state <= S_EVAL;
            // Receive wins over transmit to keep overrun risk low.
            S_EVAL: begin
               r_status <= acia_dout;
               if (acia_dout[ACIA_ST_RXF]) begin
                  r_state <= S_RXRD;
               end else if (acia_dout[ACIA_ST_TXE] && w_any) begin
                  r_state <= S_TX;
               end else begin
                  r_state <= S_POLL;
               end
            end
            S_RXRD:  r_state <= S_RXCAP;
            S_RXCAP: begin
               r_rx_data  <= acia_dout;
               r_rx_valid <= 1'b1;
               r_state    <= S_POLL;
            end
            S_TX:    r_state <= S_GAP;
            S_GAP:   r_state <= S_POLL;
            default: r_state <= S_MRST;
         endcase
      end
   end

   assign rx_valid  = r_rx_valid;
   assign rx_data   = r_rx_data;
   assign status    = r_status;
   assign init_done = r_init_done;

endmodule

// File: tb/tb_acia_master.sv
// Directed bench for acia_master with a minimal ACIA register model.
module tb_acia_master;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       acia_cs, acia_we, acia_rs;
   logic [7:0] acia_din;
   logic [7:0] acia_dout = 8'h00;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic       req0_ready, req1_ready;
   logic       rx_valid;
   logic [7:0] rx_data, status;
   logic       init_done;

   logic       m_rxf = 1'b0;
   logic       m_txe = 1'b1;
   logic [7:0] m_rx_byte = 8'h00;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic       v0;
      logic       v1;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] exp_din;
      logic       exp_r0;
      logic       exp_r1;
   } vec_t;

   vec_t vecs[10];

   acia_master dut (
      .clk(clk), .rst(rst),
      .acia_cs(acia_cs), .acia_we(acia_we), .acia_rs(acia_rs),
      .acia_din(acia_din), .acia_dout(acia_dout),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .status(status),
      .init_done(init_done)
   );

   always #5 clk = ~clk;

   // ACIA read port: data appears the cycle after a read strobe.
   always @(posedge clk) begin
      if (acia_cs && !acia_we)
         acia_dout <= acia_rs ? m_rx_byte : {6'b000000, m_txe, m_rxf};
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   task automatic wait_strobe(input logic we, input logic rs, input int max,
                              input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (acia_cs === 1'b1 && acia_we === we && acia_rs === rs) ok = 1'b1;
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL %s: no strobe we=%0b rs=%0b within %0d cycles", name, we, rs, max);
      end
   endtask

   initial begin
      bit ok;
      int reads, writes, readies;

      // last_grant starts at 1, so the first tie goes to req0.
      vecs[0] = '{1'b1, 1'b0, 8'h41, 8'h00, 8'h41, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h42, 8'h42, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h11, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h22, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h11, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h22, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h33, 8'h33, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 1'b1, 8'h44, 8'h55, 8'h44, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 8'h66, 8'h00, 8'h66, 1'b1, 1'b0};
      vecs[9] = '{1'b1, 1'b1, 8'h77, 8'h88, 8'h88, 1'b0, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset cs/we/rs", {29'd0, acia_cs, acia_we, acia_rs}, 32'd0);
      check("reset din", {24'd0, acia_din}, 32'd0);
      check("reset ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      check("reset rx", {23'd0, rx_valid, rx_data}, 32'd0);
      check("reset status", {24'd0, status}, 32'd0);
      check("reset init_done", {31'd0, init_done}, 32'd0);

      // Init sequence
      rst = 1'b0;
      #1;
      check("mrst strobe", {29'd0, acia_cs, acia_we, acia_rs}, 32'b110);
      check("mrst din", {24'd0, acia_din}, 32'h03);
      @(negedge clk);
      check("cfg strobe", {29'd0, acia_cs, acia_we, acia_rs}, 32'b110);
      check("cfg din", {24'd0, acia_din}, 32'h15);
      check("cfg init_done", {31'd0, init_done}, 32'd0);
      @(negedge clk);
      check("poll strobe", {29'd0, acia_cs, acia_we, acia_rs}, 32'b100);
      check("poll init_done", {31'd0, init_done}, 32'd1);
      @(negedge clk);
      check("eval no strobe", {31'd0, acia_cs}, 32'd0);
      @(negedge clk);
      check("status sampled", {24'd0, status}, 32'h02);

      // Transmit arbitration vectors
      for (int k = 0; k < 10; k++) begin
         req0_valid = vecs[k].v0;
         req1_valid = vecs[k].v1;
         req0_data  = vecs[k].d0;
         req1_data  = vecs[k].d1;
         wait_strobe(1'b1, 1'b1, 12, $sformatf("vec%0d write", k), ok);
         if (ok) begin
            check($sformatf("vec%0d din", k), {24'd0, acia_din}, {24'd0, vecs[k].exp_din});
            check($sformatf("vec%0d ready", k), {30'd0, req0_ready, req1_ready},
                  {30'd0, vecs[k].exp_r0, vecs[k].exp_r1});
         end
         @(posedge clk);
         #1;
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d gap", k), {29'd0, acia_cs, req0_ready, req1_ready}, 32'd0);
      end

      // TXE low: requester stalls, FSM keeps polling every 2 cycles
      m_txe = 1'b0;
      repeat (6) @(negedge clk);
      req0_valid = 1'b1;
      req0_data  = 8'h5C;
      reads = 0; writes = 0; readies = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (acia_cs && !acia_we && !acia_rs) reads++;
         if (acia_cs && acia_we) writes++;
         if (req0_ready || req1_ready) readies++;
      end
      check("stall reads", reads, 32'd25);
      check("stall writes", writes, 32'd0);
      check("stall readies", readies, 32'd0);
      m_txe = 1'b1;
      wait_strobe(1'b1, 1'b1, 3, "txe resume write", ok);
      if (ok) begin
         check("txe resume din", {24'd0, acia_din}, 32'h5C);
         check("txe resume ready", {30'd0, req0_ready, req1_ready}, 32'b10);
      end
      @(posedge clk);
      #1 req0_valid = 1'b0;

      // RXF and TXE together with req1 pending: receive first
      m_txe = 1'b0;
      repeat (4) @(negedge clk);
      req1_valid = 1'b1;
      req1_data  = 8'h99;
      repeat (4) @(negedge clk);
      m_rx_byte = 8'h5A;
      m_rxf = 1'b1;
      m_txe = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (acia_cs && acia_rs) ok = 1'b1;
      end
      check("rx first data access", {30'd0, ok, acia_we}, 32'b10);
      m_rxf = 1'b0;
      @(negedge clk);
      check("rx_valid not early", {31'd0, rx_valid}, 32'd0);
      @(negedge clk);
      check("rx_valid pulse", {31'd0, rx_valid}, 32'd1);
      check("rx_data", {24'd0, rx_data}, 32'h5A);
      @(negedge clk);
      check("rx_valid one cycle", {31'd0, rx_valid}, 32'd0);
      wait_strobe(1'b1, 1'b1, 6, "tx after rx write", ok);
      if (ok) begin
         check("tx after rx din", {24'd0, acia_din}, 32'h99);
         check("tx after rx ready", {30'd0, req0_ready, req1_ready}, 32'b01);
      end
      @(posedge clk);
      #1 req1_valid = 1'b0;

      // Make last_grant 0, then reset in the middle of a req1 write
      req0_valid = 1'b1;
      req0_data  = 8'h10;
      wait_strobe(1'b1, 1'b1, 12, "pre-reset write", ok);
      @(posedge clk);
      #1 req0_valid = 1'b0;
      @(negedge clk);
      req0_valid = 1'b1; req0_data = 8'h11;
      req1_valid = 1'b1; req1_data = 8'h22;
      wait_strobe(1'b1, 1'b1, 12, "tie before reset write", ok);
      if (ok) check("tie before reset din", {24'd0, acia_din}, 32'h22);
      rst = 1'b1;
      #1;
      check("reset in tx ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      check("reset in tx cs", {31'd0, acia_cs}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("re-init mrst din", {24'd0, acia_din}, 32'h03);
      check("re-init init_done", {31'd0, init_done}, 32'd0);
      @(negedge clk);
      check("re-init cfg din", {24'd0, acia_din}, 32'h15);
      wait_strobe(1'b1, 1'b1, 12, "post-reset tie write", ok);
      if (ok) begin
         check("post-reset tie din", {24'd0, acia_din}, 32'h11);
         check("post-reset tie ready", {30'd0, req0_ready, req1_ready}, 32'b10);
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
